// File: rtl/sequenciador_interrupcao.sv
// Interrupt entry/return sequencer: IDLE -> ACK -> JUMP -> HANDLER -> RETURN.
// Ports: clk, reset (sync, active-high), intr, instr_done, reti, pcBckp in;
//   ack, clr, pc_sel, pc_target, stall, int_active, int_count out.
// Optional: define SEQ_MASCARA_EN to add ie_set/ie_clr and the ie mask register.
module sequenciador_interrupcao #(
  parameter logic [25:0] HANDLER_ADDR = 26'd16,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             intr,
  input  logic             instr_done,
  input  logic             reti,
  input  logic [31:0]      pcBckp,
`ifdef SEQ_MASCARA_EN
  input  logic             ie_set,
  input  logic             ie_clr,
`endif
  output logic             ack,
  output logic             clr,
  output logic             pc_sel,
  output logic [25:0]      pc_target,
  output logic             stall,
  output logic             int_active,
  output logic [CNT_W-1:0] int_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACK  = 3'd1;
  localparam logic [2:0] S_JUMP = 3'd2;
  localparam logic [2:0] S_HND  = 3'd3;
  localparam logic [2:0] S_RET  = 3'd4;

  logic [2:0] state;
  logic [2:0] nxt;
  logic       en;
  logic       unused_hi;

  assign unused_hi = ^pcBckp[31:26];

`ifdef SEQ_MASCARA_EN
  logic ie;

  always_ff @(posedge clk) begin
    if (reset)       ie <= 1'b1;
    else if (ie_clr) ie <= 1'b0;
    else if (ie_set) ie <= 1'b1;
  end

  assign en = ie;
`else
  assign en = 1'b1;
`endif

  always_comb begin
    nxt = S_IDLE;
    unique case (state)
      S_IDLE:  nxt = (intr && instr_done && en) ? S_ACK : S_IDLE;
      S_ACK:   nxt = S_JUMP;
      S_JUMP:  nxt = S_HND;
      S_HND:   nxt = (instr_done && reti) ? S_RET : S_HND;
      S_RET:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered
  // and line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ack        <= 1'b0;
      clr        <= 1'b0;
      pc_sel     <= 1'b0;
      pc_target  <= '0;
      stall      <= 1'b0;
      int_active <= 1'b0;
      int_count  <= '0;
    end else begin
      state      <= nxt;
      ack        <= (nxt == S_ACK);
      clr        <= (nxt == S_RET);
      pc_sel     <= (nxt == S_JUMP) || (nxt == S_RET);
      stall      <= (nxt == S_ACK) || (nxt == S_JUMP) ||
                    (nxt == S_RET);
      int_active <= (nxt == S_HND);
      if (nxt == S_JUMP)     pc_target <= HANDLER_ADDR;
      else if (nxt == S_RET) pc_target <= pcBckp[25:0];
      else                   pc_target <= '0;
      // Saturating count of interrupts taken.
      if ((nxt == S_JUMP) && (int_count != {CNT_W{1'b1}}))
        int_count <= int_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sequenciador_interrupcao.sv
// Self-checking bench for sequenciador_interrupcao.
// Directed steps followed by random stimulus against a schedule-based model.
module tb_sequenciador_interrupcao;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        intr = 1'b0;
  logic        instr_done = 1'b0;
  logic        reti = 1'b0;
  logic [31:0] pcBckp = '0;
  logic        ie_set = 1'b0;
  logic        ie_clr = 1'b0;
  logic        ack, clr, pc_sel, stall, int_active;
  logic [25:0] pc_target;
  logic [1:0]  int_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sequenciador_interrupcao #(.HANDLER_ADDR(26'd16), .CNT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .intr(intr),
    .instr_done(instr_done),
    .reti(reti),
    .pcBckp(pcBckp),
`ifdef SEQ_MASCARA_EN
    .ie_set(ie_set),
    .ie_clr(ie_clr),
`endif
    .ack(ack),
    .clr(clr),
    .pc_sel(pc_sel),
    .pc_target(pc_target),
    .stall(stall),
    .int_active(int_active),
    .int_count(int_count)
  );

  localparam int C_IDLE = 0;
  localparam int C_ACK  = 1;
  localparam int C_JMP  = 2;
  localparam int C_HND  = 3;
  localparam int C_RET  = 4;

  // Model: a schedule of upcoming cycle kinds plus a handler flag.
  int          q[$];
  bit          hnd;
  int          cnt;
  bit          ie_m = 1'b1;
  logic [25:0] rpc;
  logic [32:0] expv;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit i, input bit d,
                            input bit rt, input logic [31:0] pc,
                            input bit s, input bit c);
    int code;
    logic [25:0] tgt;
    if (r) begin
      q.delete();
      hnd = 1'b0;
      cnt = 0;
      ie_m = 1'b1;
      code = C_IDLE;
    end else begin
      if (q.size() > 0) code = q.pop_front();
      else if (hnd) begin
        if (d && rt) begin
          code = C_RET;
          rpc = pc[25:0];
          hnd = 1'b0;
          q.push_back(C_IDLE);
        end else code = C_HND;
      end else if (i && d && ie_m) begin
        code = C_ACK;
        q.push_back(C_JMP);
        q.push_back(C_HND);
      end else code = C_IDLE;
      if (code == C_HND) hnd = 1'b1;
      if (code == C_JMP && cnt < 3) cnt++;
`ifdef SEQ_MASCARA_EN
      if (c) ie_m = 1'b0;
      else if (s) ie_m = 1'b1;
`else
      if (s || c) ie_m = 1'b1;
`endif
    end
    tgt = (code == C_JMP) ? 26'd16 : (code == C_RET) ? rpc : 26'd0;
    expv = {code == C_ACK, code == C_RET,
            code == C_JMP || code == C_RET, tgt,
            code == C_ACK || code == C_JMP || code == C_RET,
            code == C_HND, cnt[1:0]};
  endtask

  task automatic step(input bit r, input bit i, input bit d,
                      input bit rt, input logic [31:0] pc,
                      input bit s = 1'b0, input bit c = 1'b0);
    reset = r;
    intr = i;
    instr_done = d;
    reti = rt;
    pcBckp = pc;
    ie_set = s;
    ie_clr = c;
    @(posedge clk);
    #1;
    model_edge(r, i, d, rt, pc, s, c);
    chk("outputs", {31'd0, ack, clr, pc_sel, pc_target, stall,
                    int_active, int_count}, {31'd0, expv});
    chk("ack_clr_excl", {63'd0, ack & clr}, 64'd0);
  endtask

  task automatic take_irq(input logic [31:0] pc);
    step(0, 1, 1, 0, pc);
    chk("irq_ack", {63'd0, ack}, 64'd1);
    step(0, 1, 0, 0, pc);
    chk("irq_jump", {37'd0, pc_sel, pc_target}, {37'd0, 1'b1, 26'd16});
    step(0, 0, 1, 0, pc);
    chk("irq_active", {63'd0, int_active}, 64'd1);
    step(0, 0, 1, 1, pc);
    chk("irq_ret", {36'd0, clr, pc_sel, pc_target},
        {36'd0, 1'b1, 1'b1, pc[25:0]});
    step(0, 0, 0, 0, pc);
    chk("irq_idle", {62'd0, int_active, stall}, 64'd0);
  endtask

  initial begin
    step(1, 0, 0, 0, '0);
    step(1, 1, 1, 1, '0);
    chk("reset_state", {31'd0, ack, clr, pc_sel, pc_target, stall,
                        int_active, int_count}, 64'd0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0);
    // intr without a boundary, and reti while idle.
    step(0, 1, 0, 0, '0);
    step(0, 1, 0, 1, '0);
    chk("no_entry_wo_done", {63'd0, ack}, 64'd0);
    step(0, 0, 1, 1, '0);
    chk("reti_idle_ignored", {63'd0, clr}, 64'd0);
    // Nominal entry.
    step(0, 1, 1, 0, 32'h0000_0A0C);
    chk("entry_ack", {62'd0, ack, stall}, 64'd3);
    step(0, 0, 0, 1, 32'h0000_0A0C);
    chk("entry_jump", {37'd0, pc_sel, pc_target}, {37'd0, 1'b1, 26'd16});
    chk("entry_count", {62'd0, int_count}, 64'd1);
    step(0, 1, 0, 0, 32'h0000_0A0C);
    chk("handler_active", {63'd0, int_active}, 64'd1);
    // No nesting while in the handler.
    for (int k = 0; k < 6; k++) begin
      step(0, k[0], 1, 0, 32'h0000_0A0C);
      chk("no_nest_ack", {63'd0, ack}, 64'd0);
    end
    chk("no_nest_count", {62'd0, int_count}, 64'd1);
    step(0, 1, 1, 1, 32'h0000_0A0C);
    chk("return_pc", {36'd0, clr, pc_sel, pc_target},
        {36'd0, 1'b1, 1'b1, 26'h0A0C});
    step(0, 1, 1, 0, 32'h0000_0A0C);
    chk("return_idle", {63'd0, int_active}, 64'd0);
    // intr still high: accepted at the next boundary.
    step(0, 1, 1, 0, '0);
    chk("reentry_ack", {63'd0, ack}, 64'd1);
    step(0, 0, 0, 0, '0);
    chk("jump_before_reset", {63'd0, pc_sel}, 64'd1);
    step(1, 1, 1, 0, '0);
    chk("reset_mid_jump", {31'd0, ack, clr, pc_sel, pc_target, stall,
                           int_active, int_count}, 64'd0);
    step(0, 0, 0, 0, '0);
    take_irq(32'h0123_4567);
`ifdef SEQ_MASCARA_EN
    step(0, 0, 0, 0, '0, 0, 1);
    step(0, 1, 1, 0, '0);
    chk("masked_no_ack", {63'd0, ack}, 64'd0);
    step(0, 1, 0, 0, '0, 1, 0);
    step(0, 1, 1, 0, '0);
    chk("unmasked_ack", {63'd0, ack}, 64'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0);
    step(0, 0, 1, 1, '0);
    step(0, 0, 0, 0, '0);
`endif
    // Saturation with a 2-bit counter.
    step(1, 0, 0, 0, '0);
    for (int n = 1; n <= 5; n++) begin
      take_irq(32'h0000_1000 + n);
      chk("sat_count", {62'd0, int_count}, (n < 3) ? n : 3);
    end
    // Random stimulus against the model.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom, $urandom_range(0, 9) == 0,
           $urandom_range(0, 15) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
